// File: rtl/qpd_sequencer.sv
// Quarter-period-delay trigger sequencer.
// Each point of a run waits for a rising edge on the reference input.
// It then counts the configured delay and fires a one-cycle ADC trigger.
// Next it waits for the ADC acknowledge, with a timeout.
// Finally it idles for the configured gap before re-arming for the next point.

module qpd_sequencer #(
    parameter int unsigned SAMPLE_FREQUENCY = 100000,
    parameter int unsigned TIMEOUT_CYCLES   = 1000,
    parameter int unsigned COUNT_W          = 16
) (
    input  logic               sclock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               rt,
    input  logic [7:0]         cfg_delay,
    input  logic [COUNT_W-1:0] cfg_count,
    input  logic [COUNT_W-1:0] cfg_gap,
    input  logic               adc_done,
    output logic               trigger,
    output logic               busy,
    output logic               done,
    output logic               timeout_err,
    output logic [COUNT_W-1:0] trig_index
);

    // The timeout counter is 16 bits wide.
    // Reject settings it cannot hold, and a meaningless sample rate.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535 || SAMPLE_FREQUENCY == 0) begin : g_param_check
        $error("qpd_sequencer: TIMEOUT_CYCLES must be 1..65535 and SAMPLE_FREQUENCY nonzero");
    end

    localparam logic [15:0]        TIMEOUT_LOAD = 16'(TIMEOUT_CYCLES);
    localparam logic [COUNT_W-1:0] ONE_C        = COUNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_REF,
        DELAY,
        TRIG,
        WAIT_DONE,
        GAP,
        FINISH
    } state_e;

    state_e             state_q,       state_d;
    logic               rt_q;
    logic [7:0]         dly_cfg_q,     dly_cfg_d;
    logic [COUNT_W-1:0] num_cfg_q,     num_cfg_d;
    logic [COUNT_W-1:0] gap_cfg_q,     gap_cfg_d;
    logic [7:0]         dly_cnt_q,     dly_cnt_d;
    logic [COUNT_W-1:0] gap_cnt_q,     gap_cnt_d;
    logic [15:0]        to_cnt_q,      to_cnt_d;
    logic               done_flag_q,   done_flag_d;
    logic               trigger_q,     trigger_d;
    logic               busy_q,        busy_d;
    logic               done_q,        done_d;
    logic               timeout_err_q, timeout_err_d;
    logic [COUNT_W-1:0] trig_index_q,  trig_index_d;

    logic rt_rise;
    logic ack;

    // The edge is seen every cycle, but only WAIT_REF acts on it.
    assign rt_rise = rt & ~rt_q;

    // An acknowledge that arrived during TRIG is held one cycle and honoured here.
    assign ack = adc_done | done_flag_q;

    // Next-state and next-output computation for the whole sequencer.
    always_comb begin
        // NOTE: every _d takes its _q value (or an idle value) first.
        // A branch that forgets to assign then holds state instead of inferring a latch.
        state_d       = state_q;
        dly_cfg_d     = dly_cfg_q;
        num_cfg_d     = num_cfg_q;
        gap_cfg_d     = gap_cfg_q;
        dly_cnt_d     = dly_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        to_cnt_d      = to_cnt_q;
        done_flag_d   = 1'b0;
        trigger_d     = 1'b0;
        done_d        = 1'b0;
        timeout_err_d = timeout_err_q;
        trig_index_d  = trig_index_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dly_cfg_d     = cfg_delay;
                    num_cfg_d     = cfg_count;
                    gap_cfg_d     = cfg_gap;
                    trig_index_d  = '0;
                    timeout_err_d = 1'b0;
                    state_d       = (cfg_count == '0) ? FINISH : WAIT_REF;
                end
            end

            WAIT_REF: begin
                if (rt_rise) begin
                    dly_cnt_d = dly_cfg_q;
                    if (dly_cfg_q == 8'd0) begin
                        state_d   = TRIG;
                        trigger_d = 1'b1;
                        if (trig_index_q < num_cfg_q) begin
                            trig_index_d = trig_index_q + ONE_C;
                        end
                    end else begin
                        state_d = DELAY;
                    end
                end
            end

            DELAY: begin
                // Leaving at a count of 1 puts the trigger exactly D+1 cycles after the edge.
                if (dly_cnt_q <= 8'd1) begin
                    dly_cnt_d = 8'd0;
                    state_d   = TRIG;
                    trigger_d = 1'b1;
                    if (trig_index_q < num_cfg_q) begin
                        trig_index_d = trig_index_q + ONE_C;
                    end
                end else begin
                    dly_cnt_d = dly_cnt_q - 8'd1;
                end
            end

            TRIG: begin
                to_cnt_d    = TIMEOUT_LOAD;
                done_flag_d = adc_done;
                state_d     = WAIT_DONE;
            end

            WAIT_DONE: begin
                if (ack) begin
                    to_cnt_d = 16'd0;
                    if (trig_index_q == num_cfg_q) begin
                        state_d = FINISH;
                    end else if (gap_cfg_q == '0) begin
                        state_d = WAIT_REF;
                    end else begin
                        gap_cnt_d = gap_cfg_q;
                        state_d   = GAP;
                    end
                end else if (to_cnt_q <= 16'd1) begin
                    // The acknowledge window is TIMEOUT_CYCLES cycles of WAIT_DONE.
                    to_cnt_d      = 16'd0;
                    timeout_err_d = 1'b1;
                    state_d       = FINISH;
                end else begin
                    to_cnt_d = to_cnt_q - 16'd1;
                end
            end

            GAP: begin
                if (gap_cnt_q <= ONE_C) begin
                    gap_cnt_d = '0;
                    state_d   = WAIT_REF;
                end else begin
                    gap_cnt_d = gap_cnt_q - ONE_C;
                end
            end

            FINISH: begin
                done_d  = ~timeout_err_q;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over everything else in any active state.
        // It drops any trigger, done or timeout decided this cycle.
        if (abort && state_q != IDLE) begin
            state_d       = IDLE;
            trigger_d     = 1'b0;
            done_d        = 1'b0;
            done_flag_d   = 1'b0;
            timeout_err_d = timeout_err_q;
            trig_index_d  = trig_index_q;
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sclock) begin
        // NOTE: non-blocking assignments only.
        // Every flop samples the pre-edge values, whatever the statement order.
        if (reset) begin
            state_q       <= IDLE;
            rt_q          <= 1'b0;
            dly_cfg_q     <= 8'd0;
            num_cfg_q     <= '0;
            gap_cfg_q     <= '0;
            dly_cnt_q     <= 8'd0;
            gap_cnt_q     <= '0;
            to_cnt_q      <= 16'd0;
            done_flag_q   <= 1'b0;
            trigger_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            trig_index_q  <= '0;
        end else begin
            state_q       <= state_d;
            rt_q          <= rt;
            dly_cfg_q     <= dly_cfg_d;
            num_cfg_q     <= num_cfg_d;
            gap_cfg_q     <= gap_cfg_d;
            dly_cnt_q     <= dly_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            to_cnt_q      <= to_cnt_d;
            done_flag_q   <= done_flag_d;
            trigger_q     <= trigger_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
            trig_index_q  <= trig_index_d;
        end
    end

    assign trigger     = trigger_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;
    assign trig_index  = trig_index_q;

endmodule
